spi_slave_rx_tx: RTL and testbench

Mode-0 SPI slave: the far end of the team's SPI master link. It oversamples the external spi_sclk/spi_cs/spi_mosi pins in the sys_clk domain, shifts received bits MSB-first into a byte register, and drives spi_miso MSB-first from a user-supplied transmit byte. It sits between the SPI pins and user logic, exchanging one byte per 8 SCLK cycles with single-cycle strobes on the user side.

---
 rtl/spi_slave_rx_tx.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI slave: pins oversampled in sys_clk, MSB-first receive into rx_data,
// MSB-first transmit of tx_data on spi_miso, single-cycle strobes toward user logic.
//
// state  | meaning
// IDLE   | synchronized CS high; SCLK edges ignored, spi_miso held 0
// ACTIVE | frame open; sample MOSI on SCLK rise, drive MISO on SCLK fall
module spi_slave_rx_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [WARM_W-1:0]      warm_cnt;
    logic                   armed;

    logic [CNT_W-1:0]       bit_cnt;
    logic                   byte_done;
    logic [DATA_W-1:0]      rx_shift, tx_shift;
    logic                   rx_pend;

    logic                   do_load, do_sample, do_shift, do_end;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = armed & ~cs_s & cs_d;

    // A CS already low when reset releases must not look like a new frame:
    // only arm once the synchronizer holds real pin data and CS reads high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else if (warm_cnt != WARM_W'(SYNC_STAGES)) begin
            warm_cnt <= warm_cnt + 1'b1;
        end else if (cs_s) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_load   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        do_end    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nx = ACTIVE;
                    do_load  = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_nx = IDLE;
                    do_end   = 1'b1;
                end else if (sclk_rise) begin
                    do_sample = 1'b1;
                end else if (sclk_fall) begin
                    if (byte_done) do_load  = 1'b1;
                    else           do_shift = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            spi_miso   <= 1'b0;
            rx_data    <= '0;
            rx_pend    <= 1'b0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rx_pend    <= 1'b0;
            rx_valid   <= rx_pend;
            tx_req     <= do_load;
            frame_done <= do_end;
            if (do_end) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                rx_shift  <= '0;
                spi_miso  <= 1'b0;
            end else if (do_load) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                tx_shift  <= tx_data << 1;
                spi_miso  <= tx_data[DATA_W-1];
            end else if (do_sample) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    rx_data   <= {rx_shift[DATA_W-2:0], mosi_s};
                    rx_pend   <= 1'b1;
                    bit_cnt   <= '0;
                    byte_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (do_shift) begin
                spi_miso <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed and randomized bench for spi_slave_rx_tx; a mode-0 master model
// at sys_clk/8 exchanges bytes and results are compared against queued expectations.
module tb_spi_slave_rx_tx;

    logic       sys_clk, sys_rst_n;
    logic       spi_sclk, spi_cs, spi_mosi, spi_miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_req, rx_valid, busy, frame_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] tx_b[$];
    logic [7:0] mosi_b[$];
    logic [7:0] rx_got[$];
    logic [7:0] miso_got[$];
    int         n_txreq, n_fd;

    spi_slave_rx_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, spi_miso, rx_valid, tx_req, busy, frame_done, rx_data};
    endfunction

    // One sys_clk cycle: wait for the falling edge, then log user-side strobes
    // and hand the next queued byte to tx_data whenever tx_req pulses.
    task automatic tick();
        @(negedge sys_clk);
        if (sys_rst_n) begin
            if (rx_valid) rx_got.push_back(rx_data);
            if (tx_req) begin
                n_txreq++;
                if (tx_q.size() > 0) tx_data = tx_q.pop_front();
            end
            if (frame_done) n_fd++;
        end
    endtask

    task automatic frame(input int nbits, input bit close);
        logic [7:0] acc, cur;
        int         start_at, rxv_at;
        logic       txreq_at_start, miso_at_start;
        rx_got.delete();
        miso_got.delete();
        n_txreq = 0;
        n_fd    = 0;
        tx_data = tx_b[0];
        tx_q.delete();
        for (int k = 1; k < tx_b.size(); k++) tx_q.push_back(tx_b[k]);
        tick();
        spi_cs = 1'b0;
        start_at = 0;
        txreq_at_start = 1'b0;
        miso_at_start  = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (busy && start_at == 0) begin
                start_at       = j;
                txreq_at_start = tx_req;
                miso_at_start  = spi_miso;
            end
        end
        cur = tx_b[0];
        chk("start_latency", start_at, 3);
        chk("start_tx_req", txreq_at_start, 1);
        chk("start_msb", miso_at_start, cur[7]);
        acc = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            cur = mosi_b[i / 8];
            spi_mosi = cur[7 - (i % 8)];
            repeat (4) tick();
            acc = {acc[6:0], spi_miso};
            spi_sclk = 1'b1;
            rxv_at = 0;
            for (int j = 1; j <= 4; j++) begin
                tick();
                if (rx_valid) rxv_at = j;
            end
            if (i % 8 == 7) begin
                miso_got.push_back(acc);
                chk("rx_valid_latency", rxv_at, 4);
            end
            spi_sclk = 1'b0;
        end
        if (close) begin
            repeat (6) tick();
            spi_cs = 1'b1;
            repeat (6) tick();
        end
    endtask

    task automatic verify(input string tag, input int nfull);
        logic [31:0] got;
        int          idx;
        chk({tag, "_rx_count"}, rx_got.size(), nfull);
        chk({tag, "_tx_req_count"}, n_txreq, nfull + 1);
        chk({tag, "_frame_done_count"}, n_fd, 1);
        for (int k = 0; k < nfull; k++) begin
            got = (k < rx_got.size()) ? {24'd0, rx_got[k]} : 32'hDEAD;
            chk({tag, "_rx_byte"}, got, {24'd0, mosi_b[k]});
            idx = (k < tx_b.size()) ? k : tx_b.size() - 1;
            got = (k < miso_got.size()) ? {24'd0, miso_got[k]} : 32'hDEAD;
            chk({tag, "_miso_byte"}, got, {24'd0, tx_b[idx]});
        end
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_miso_idle"}, spi_miso, 0);
    endtask

    initial begin
        int         nb, nt, busy_seen, miso_seen, txr0;
        logic [7:0] last_rx;

        sys_rst_n = 1'b0;
        spi_sclk  = 1'b0;
        spi_cs    = 1'b1;
        spi_mosi  = 1'b0;
        tx_data   = 8'h00;
        n_txreq   = 0;
        n_fd      = 0;

        for (int c = 0; c < 12; c++) begin
            spi_sclk = 1'($urandom);
            spi_cs   = 1'($urandom);
            spi_mosi = 1'($urandom);
            tick();
            if (c % 3 == 2) chk("reset_outputs", outs(), 0);
        end
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        repeat (8) tick();
        chk("post_reset_outputs", outs(), 0);

        tx_b   = '{8'hA5};
        mosi_b = '{8'h3C};
        frame(8, 1'b1);
        verify("single", 1);
        chk("single_rx_data_hold", rx_data, 8'h3C);

        tx_b   = '{8'h81, 8'h7E};
        mosi_b = '{8'hFF, 8'h00};
        frame(16, 1'b1);
        verify("b2b", 2);
        last_rx = rx_data;

        tx_b   = '{8'h3C};
        mosi_b = '{8'hC3};
        frame(5, 1'b1);
        chk("abort_rx_count", rx_got.size(), 0);
        chk("abort_rx_data_kept", rx_data, last_rx);
        chk("abort_frame_done", n_fd, 1);
        chk("abort_miso", spi_miso, 0);
        chk("abort_busy", busy, 0);

        tx_b   = '{8'h5A};
        mosi_b = '{8'h96};
        frame(8, 1'b1);
        verify("after_abort", 1);

        tx_b   = '{8'h77};
        mosi_b = '{8'hE1};
        frame(3, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        chk("reset_mid_async", outs(), 0);
        tx_q.delete();
        repeat (2) tick();
        chk("reset_mid_hold", outs(), 0);
        sys_rst_n = 1'b1;
        n_txreq   = 0;
        busy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (busy) busy_seen++;
        end
        chk("cs_low_at_release_busy", busy_seen, 0);
        chk("cs_low_at_release_tx_req", n_txreq, 0);
        spi_cs = 1'b1;
        repeat (6) tick();
        tx_b   = '{8'h12};
        mosi_b = '{8'h34};
        frame(8, 1'b1);
        verify("after_reset", 1);

        for (int f = 0; f < 4; f++) begin
            nb = $urandom_range(1, 3);
            nt = $urandom_range(1, nb);
            tx_b.delete();
            mosi_b.delete();
            for (int k = 0; k < nt; k++) tx_b.push_back(8'($urandom));
            for (int k = 0; k < nb; k++) mosi_b.push_back(8'($urandom));
            frame(nb * 8, 1'b1);
            verify("random", nb);
            chk("random_rx_data_last", rx_data, mosi_b[nb - 1]);
        end

        last_rx   = rx_data;
        rx_got.delete();
        n_txreq   = 0;
        n_fd      = 0;
        busy_seen = 0;
        miso_seen = 0;
        txr0      = 0;
        spi_cs    = 1'b1;
        for (int p = 0; p < 16; p++) begin
            spi_mosi = 1'($urandom);
            repeat (4) begin
                tick();
                if (busy) busy_seen++;
                if (spi_miso) miso_seen++;
            end
            spi_sclk = 1'b1;
            spi_mosi = 1'($urandom);
            repeat (4) begin
                tick();
                if (busy) busy_seen++;
                if (spi_miso) miso_seen++;
            end
            spi_sclk = 1'b0;
        end
        repeat (6) tick();
        chk("noise_rx_valid", rx_got.size(), 0);
        chk("noise_tx_req", n_txreq, txr0);
        chk("noise_busy", busy_seen, 0);
        chk("noise_miso", miso_seen, 0);
        chk("noise_frame_done", n_fd, 0);
        chk("noise_rx_data_kept", rx_data, last_rx);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
